// File: rtl/load_sched_pkg.sv
// Shared types for the load command scheduler: FSM states, AXI response code
// and the packed 45-bit load command carried through the command FIFO.
package load_sched_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int ID_W   = 8;
  localparam int ADDR_W = 12;
  localparam int LEN_W  = 8;
  localparam int SIZE_W = 3;
  localparam int TYPE_W = 2;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_AR,
    WAIT_R,
    CHECK,
    REPORT
  } state_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] dram_addr;
    logic [LEN_W-1:0]  len;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] ld_addr;
    logic [TYPE_W-1:0] sram_type;
  } load_cmd_t;

endpackage

// File: rtl/load_cmd_fifo.sv
// Command queue for the load scheduler; head entry is visible combinationally.
module load_cmd_fifo
  import load_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  logic      pop,
  input  load_cmd_t wdata,
  output load_cmd_t head,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);

  load_cmd_t   mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (pop && !empty)
        rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/load_cmd_scheduler.sv
// Issues queued DRAM-to-SRAM load commands one at a time and reports completion.
// Optional retry of errored commands is enabled by defining LOAD_SCHED_RETRY_EN.
module load_cmd_scheduler
  import load_sched_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [7:0]  cmd_id,
  input  logic [11:0] cmd_dram_addr,
  input  logic [7:0]  cmd_len,
  input  logic [2:0]  cmd_size,
  input  logic [11:0] cmd_ld_addr,
  input  logic [1:0]  cmd_sram_type,
  output logic        ctrl_load_vld,
  output logic [7:0]  ctrl_load_id,
  output logic [11:0] ctrl_load_dram_addr,
  output logic [7:0]  ctrl_load_len,
  output logic [2:0]  ctrl_load_size,
  output logic [11:0] ctrl_load_ld_addr,
  output logic [1:0]  ctrl_load_sram_type,
  input  logic        axi_arvld,
  input  logic        axi_arrdy,
  input  logic        axi_rvld,
  input  logic        axi_rrdy,
  input  logic        axi_rlast,
  input  logic [1:0]  axi_rresp,
  input  logic [7:0]  axi_rid,
  output logic        done_vld,
  output logic [7:0]  done_id,
  output logic        done_err,
  output logic        busy
);

  state_t     state, state_nxt;
  load_cmd_t  cmd_in, head, head_vis;
  logic       fifo_full, fifo_empty, push, pop;
  logic [8:0] beat_cnt, beat_cnt_inc;
  logic       err_flag, beat_acc, beat_err, retry_ok;

  assign cmd_in = '{id: cmd_id, dram_addr: cmd_dram_addr, len: cmd_len,
                    size: cmd_size, ld_addr: cmd_ld_addr, sram_type: cmd_sram_type};
  assign cmd_rdy = ~fifo_full;
  assign push    = cmd_vld & ~fifo_full;

  load_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (cmd_in),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Unwritten FIFO storage must not leak onto the payload outputs.
  assign head_vis            = fifo_empty ? '0 : head;
  assign ctrl_load_id        = head_vis.id;
  assign ctrl_load_dram_addr = head_vis.dram_addr;
  assign ctrl_load_len       = head_vis.len;
  assign ctrl_load_size      = head_vis.size;
  assign ctrl_load_ld_addr   = head_vis.ld_addr;
  assign ctrl_load_sram_type = head_vis.sram_type;

  assign beat_acc     = (state == WAIT_R) & axi_rvld & axi_rrdy & (axi_rid == head.id);
  assign beat_cnt_inc = beat_cnt + 9'd1;
  assign beat_err     = (axi_rresp != RESP_OKAY)
                      | (axi_rlast & (beat_cnt != {1'b0, head.len}))
                      | (~axi_rlast & (beat_cnt_inc > {1'b0, head.len}));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      err_flag <= 1'b0;
    end else if (state == ISSUE) begin
      beat_cnt <= '0;
      err_flag <= 1'b0;
    end else if (beat_acc) begin
      if (beat_cnt != '1)
        beat_cnt <= beat_cnt_inc;
      if (beat_err)
        err_flag <= 1'b1;
    end
  end

`ifdef LOAD_SCHED_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0] retry_cnt;

  assign retry_ok = err_flag & (retry_cnt < RETRY_W'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retry_cnt <= '0;
    else if ((state == CHECK) && retry_ok)
      retry_cnt <= retry_cnt + RETRY_W'(1);
    else if (state == REPORT)
      retry_cnt <= '0;
  end
`else
  assign retry_ok = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (!fifo_empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT_AR;
      WAIT_AR: if (axi_arvld && axi_arrdy) state_nxt = WAIT_R;
      WAIT_R:  if (beat_acc && axi_rlast) state_nxt = CHECK;
      CHECK:   state_nxt = retry_ok ? ISSUE : REPORT;
      REPORT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ctrl_load_vld = (state == ISSUE);
    done_vld      = (state == REPORT);
    done_err      = (state == REPORT) & err_flag;
    done_id       = (state == REPORT) ? head.id : '0;
    pop           = (state == REPORT);
    busy          = ~fifo_empty | (state != IDLE);
  end

endmodule
